sha2_sched: RTL and testbench

SHA2_SCHED -- requirements
Module: sha2_sched

---
 rtl/sha2_sched.sv | 226 ++++++++++++++++++++++
 tb/tb_sha2_sched.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha2_sched.sv
`default_nettype none
// ============================================================================
// Module   : sha2_sched
// Purpose  : Shares one SHA-2 engine among N_SRC requesters. Packets are
//            granted round-robin, one whole packet at a time. Each grant
//            pushes the requester index into an in-order tag FIFO. Returning
//            digests are steered back to the requester at the FIFO head.
// Ports    : aclk, aresetn         - clock; asynchronous active-low reset
//            s_t*                  - N_SRC requester message streams
//            m_t*                  - message feed to the engine sink
//            d_t*                  - digest stream from the engine source
//            r_t*                  - digest returned to the owning requester
//            inflight              - packets currently tagged in the engine
//            err_orphan            - sticky: a digest arrived with no tag
//            stat_pkt              - per-requester completed-digest counters
// Config   : SHA2_SCHED_STATS_EN   - when defined, builds the 32-bit
//                                    stat_pkt counters (otherwise tied to 0)
// Notes    : TAG_DEPTH must be a power of two and at least 2.
// Revision : 1.0 - initial release
// ============================================================================
module sha2_sched #(
    parameter int N_SRC     = 4,
    parameter int TAG_DEPTH = 8
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic [N_SRC*512-1:0]         s_tdata,
    input  logic [N_SRC-1:0]             s_tvalid,
    input  logic [N_SRC-1:0]             s_tlast,
    output logic [N_SRC-1:0]             s_tready,
    output logic [511:0]                 m_tdata,
    output logic                         m_tvalid,
    output logic                         m_tlast,
    input  logic                         m_tready,
    input  logic [511:0]                 d_tdata,
    input  logic                         d_tvalid,
    input  logic                         d_tlast,
    output logic                         d_tready,
    output logic [511:0]                 r_tdata,
    output logic                         r_tlast,
    output logic [N_SRC-1:0]             r_tvalid,
    input  logic [N_SRC-1:0]             r_tready,
    output logic [$clog2(TAG_DEPTH):0]   inflight,
    output logic                         err_orphan,
    output logic [N_SRC*32-1:0]          stat_pkt
);

    localparam int SRC_W = $clog2(N_SRC);
    localparam int PTR_W = $clog2(TAG_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SRC_W-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_orphan_q, err_orphan_d;
    logic [SRC_W-1:0]   tag_mem_q [TAG_DEPTH];

    logic               push;
    logic               pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [SRC_W-1:0]   head;
    logic               found;
    logic [SRC_W-1:0]   cand;
    logic [SRC_W-1:0]   pick;

    assign fifo_full  = (count_q == CNT_W'(TAG_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign head       = tag_mem_q[rd_ptr_q];

    // ------------------------------------------------------------------
    // Request side: round-robin pick and packet-granular transfer FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        push     = 1'b0;
        s_tready = '0;
        m_tdata  = '0;
        m_tvalid = 1'b0;
        m_tlast  = 1'b0;

        // First valid requester at or after rr_ptr, wrapping at N_SRC.
        found = 1'b0;
        cand  = rr_ptr_q;
        pick  = rr_ptr_q;
        for (int k = 0; k < N_SRC; k++) begin
            if (!found && s_tvalid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
            cand = (cand == SRC_W'(N_SRC - 1)) ? '0 : cand + SRC_W'(1);
        end

        case (state_q)
            ST_IDLE: begin
                // Outputs stay quiet here; this costs one bubble per packet.
                if (found && !fifo_full) begin
                    grant_d = pick;
                    push    = 1'b1;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (grant_q == SRC_W'(i)) begin
                        m_tdata     = s_tdata[i*512 +: 512];
                        m_tvalid    = s_tvalid[i];
                        m_tlast     = s_tlast[i];
                        s_tready[i] = m_tready;
                    end
                end
                if (m_tvalid && m_tready && m_tlast) begin
                    rr_ptr_d = (grant_q == SRC_W'(N_SRC - 1)) ? '0 : grant_q + SRC_W'(1);
                    state_d  = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Return side: digest steered to the tag at the FIFO head
    // ------------------------------------------------------------------
    always_comb begin
        r_tvalid = '0;
        d_tready = 1'b0;
        // With no tag the digest is held off and flagged as an orphan.
        if (!fifo_empty) begin
            for (int i = 0; i < N_SRC; i++) begin
                if (head == SRC_W'(i)) begin
                    r_tvalid[i] = d_tvalid;
                    d_tready    = r_tready[i];
                end
            end
        end
    end

    assign r_tdata = d_tdata;
    assign r_tlast = d_tlast;
    assign pop     = d_tvalid & d_tready & d_tlast;

    // ------------------------------------------------------------------
    // Tag FIFO bookkeeping
    // ------------------------------------------------------------------
    always_comb begin
        wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d      = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
        err_orphan_d = err_orphan_q | (d_tvalid & fifo_empty);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            rr_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            rr_ptr_q     <= rr_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    // Tag storage needs no reset: entries are only read while count_q > 0.
    always_ff @(posedge aclk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= grant_d;
        end
    end

    assign inflight   = count_q;
    assign err_orphan = err_orphan_q;

    // ------------------------------------------------------------------
    // Optional per-requester completion counters
    // ------------------------------------------------------------------
`ifdef SHA2_SCHED_STATS_EN
    for (genvar g = 0; g < N_SRC; g++) begin : g_stats
        logic [31:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (pop && (head == SRC_W'(g))) begin
                cnt_d = cnt_q + 32'd1;
            end
        end

        always_ff @(posedge aclk or negedge aresetn) begin
            if (!aresetn) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign stat_pkt[g*32 +: 32] = cnt_q;
    end
`else
    assign stat_pkt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sha2_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_sha2_sched
// Purpose  : Self-checking bench for sha2_sched (N_SRC=4, TAG_DEPTH=8).
//            Bench-side source queues drive the requester streams, a small
//            engine model turns each finished packet into a digest, and
//            scoreboards hold the expected beat order and return one-hots.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sha2_sched;

    localparam int N = 4;

    logic               aclk = 1'b0;
    logic               aresetn = 1'b1;
    logic [N*512-1:0]   s_tdata = '0;
    logic [N-1:0]       s_tvalid = '0;
    logic [N-1:0]       s_tlast = '0;
    logic [N-1:0]       s_tready;
    logic [511:0]       m_tdata;
    logic               m_tvalid;
    logic               m_tlast;
    logic               m_tready = 1'b0;
    logic [511:0]       d_tdata = '0;
    logic               d_tvalid = 1'b0;
    logic               d_tlast = 1'b0;
    logic               d_tready;
    logic [511:0]       r_tdata;
    logic               r_tlast;
    logic [N-1:0]       r_tvalid;
    logic [N-1:0]       r_tready = '0;
    logic [3:0]         inflight;
    logic               err_orphan;
    logic [N*32-1:0]    stat_pkt;

    sha2_sched #(.N_SRC(N), .TAG_DEPTH(8)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .s_tdata    (s_tdata),
        .s_tvalid   (s_tvalid),
        .s_tlast    (s_tlast),
        .s_tready   (s_tready),
        .m_tdata    (m_tdata),
        .m_tvalid   (m_tvalid),
        .m_tlast    (m_tlast),
        .m_tready   (m_tready),
        .d_tdata    (d_tdata),
        .d_tvalid   (d_tvalid),
        .d_tlast    (d_tlast),
        .d_tready   (d_tready),
        .r_tdata    (r_tdata),
        .r_tlast    (r_tlast),
        .r_tvalid   (r_tvalid),
        .r_tready   (r_tready),
        .inflight   (inflight),
        .err_orphan (err_orphan),
        .stat_pkt   (stat_pkt)
    );

    always #5 aclk = ~aclk;

    int n_chk  = 0;
    int n_fail = 0;

    // Beat word: {src, pkt, beat, 7'b0, last}
    logic [31:0] src_q [N][$];
    logic [31:0] exp_m [$];
    int          exp_r [$];
    logic [31:0] dig_q [$];
    bit          d_en    = 1'b0;
    bit          gap_en  = 1'b0;
    int          cyc     = 0;
    int          last_cyc = -1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] w(input int s, input int p, input int b, input bit l);
        return {s[7:0], p[7:0], b[7:0], 7'd0, l};
    endfunction

    // Source drivers, engine model and scoreboard monitors.
    // Sample at negedge, update stimulus 1 time unit after posedge.
    initial begin : drv
        logic [N-1:0] s_hs;
        logic         m_hs;
        logic         m_last_s;
        logic [7:0]   m_src_s;
        logic         d_hs;
        logic [31:0]  e;
        int           es;
        forever begin
            @(negedge aclk);
            cyc++;
            s_hs     = s_tvalid & s_tready;
            m_hs     = m_tvalid & m_tready;
            m_last_s = m_tlast;
            m_src_s  = m_tdata[31:24];
            d_hs     = d_tvalid & d_tready;
            if (m_hs) begin
                if (exp_m.size() == 0) begin
                    check("m_unexpected_beat", 64'(m_tdata[31:0]), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    e = exp_m.pop_front();
                    check("m_data", 64'(m_tdata[31:0]), 64'(e));
                    check("m_last", 64'(m_tlast), 64'(e[0]));
                    check("s_tready_onehot", 64'(s_tready), 64'(1) << e[31:24]);
                    if (gap_en && last_cyc >= 0)
                        check("m_beat_gap", 64'(cyc - last_cyc), (e[15:8] == 8'd0) ? 64'd2 : 64'd1);
                    last_cyc = cyc;
                end
            end
            if (|(r_tvalid & r_tready)) begin
                if (exp_r.size() == 0) begin
                    check("r_unexpected", 64'(r_tvalid), 64'd0);
                end else begin
                    es = exp_r.pop_front();
                    check("r_onehot", 64'(r_tvalid), 64'(1) << es);
                    check("r_data", 64'(r_tdata[31:0]), 64'(32'hD000_0000 | 32'(es)));
                end
            end
            @(posedge aclk);
            #1;
            for (int i = 0; i < N; i++)
                if (s_hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (m_hs && m_last_s) dig_q.push_back(32'hD000_0000 | 32'(m_src_s));
            if (d_hs && dig_q.size() > 0) void'(dig_q.pop_front());
            for (int i = 0; i < N; i++) begin
                s_tvalid[i] = (src_q[i].size() > 0);
                s_tdata[i*512 +: 512] = (src_q[i].size() > 0) ? {480'd0, src_q[i][0]} : '0;
                s_tlast[i] = (src_q[i].size() > 0) ? src_q[i][0][0] : 1'b0;
            end
            d_tvalid = d_en && (dig_q.size() > 0);
            d_tdata  = (dig_q.size() > 0) ? {480'd0, dig_q[0]} : '0;
            d_tlast  = 1'b1;
        end
    end

    task automatic check_rst(input string tag);
        check({tag, "_s_tready"},   64'(s_tready),       64'd0);
        check({tag, "_m_tvalid"},   64'(m_tvalid),       64'd0);
        check({tag, "_r_tvalid"},   64'(r_tvalid),       64'd0);
        check({tag, "_d_tready"},   64'(d_tready),       64'd0);
        check({tag, "_inflight"},   64'(inflight),       64'd0);
        check({tag, "_err_orphan"}, 64'(err_orphan),     64'd0);
        check({tag, "_stat_lo"},    stat_pkt[63:0],      64'd0);
        check({tag, "_stat_hi"},    stat_pkt[127:64],    64'd0);
    endtask

    task automatic do_reset(input string tag);
        aresetn = 1'b0;
        #1;
        check_rst(tag);
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_m.delete();
        exp_r.delete();
        dig_q.delete();
        d_en = 1'b0;
        repeat (2) @(posedge aclk);
        #3;
        aresetn = 1'b1;
        @(posedge aclk);
        #2;
    endtask

    task automatic wait_drain(input string tag, input bit all, input int limit);
        int  n = 0;
        bit  busy = 1'b1;
        while (busy && n < limit) begin
            @(posedge aclk);
            #2;
            n++;
            busy = (exp_m.size() != 0);
            if (all) begin
                busy = busy || (exp_r.size() != 0) || (dig_q.size() != 0);
                for (int i = 0; i < N; i++) busy = busy || (src_q[i].size() != 0);
            end
        end
        check({tag, "_timeout"}, 64'(n >= limit), 64'd0);
    endtask

    initial begin : main
        logic [127:0] exp_stat;
        int srcs [3];
        #2;
        do_reset("rst0");

        // Orphan digest with no tags outstanding
        r_tready = '1;
        d_en     = 1'b1;
        dig_q.push_back(32'h0000_0BAD);
        repeat (3) @(posedge aclk);
        #2;
        check("orph_d_tready", 64'(d_tready), 64'd0);
        check("orph_r_tvalid", 64'(r_tvalid), 64'd0);
        check("orph_flag", 64'(err_orphan), 64'd1);
        dig_q.delete();
        repeat (3) @(posedge aclk);
        #2;
        check("orph_sticky", 64'(err_orphan), 64'd1);
        aresetn = 1'b0;
        #1;
        check("orph_cleared", 64'(err_orphan), 64'd0);
        aresetn = 1'b1;
        do_reset("rst1");

        // Sources 0 and 2, single-beat packets: grant 0,2,0,2
        m_tready = 1'b1;
        r_tready = '1;
        d_en     = 1'b1;
        gap_en   = 1'b1;
        last_cyc = -1;
        src_q[0].push_back(w(0, 1, 0, 1));
        src_q[0].push_back(w(0, 3, 0, 1));
        src_q[2].push_back(w(2, 2, 0, 1));
        src_q[2].push_back(w(2, 4, 0, 1));
        exp_m.push_back(w(0, 1, 0, 1));
        exp_m.push_back(w(2, 2, 0, 1));
        exp_m.push_back(w(0, 3, 0, 1));
        exp_m.push_back(w(2, 4, 0, 1));
        exp_r.push_back(0); exp_r.push_back(2); exp_r.push_back(0); exp_r.push_back(2);
        wait_drain("rr02", 1'b1, 200);
        gap_en = 1'b0;
        check("rr02_inflight", 64'(inflight), 64'd0);

        // Move rr_ptr to 1 with a lone packet from source 0
        src_q[0].push_back(w(0, 5, 0, 1));
        exp_m.push_back(w(0, 5, 0, 1));
        exp_r.push_back(0);
        wait_drain("pre", 1'b1, 200);

        // Source 1 three-beat packet is not interrupted by source 3
        gap_en   = 1'b1;
        last_cyc = -1;
        src_q[1].push_back(w(1, 6, 0, 0));
        src_q[1].push_back(w(1, 6, 1, 0));
        src_q[1].push_back(w(1, 6, 2, 1));
        src_q[3].push_back(w(3, 7, 0, 1));
        exp_m.push_back(w(1, 6, 0, 0));
        exp_m.push_back(w(1, 6, 1, 0));
        exp_m.push_back(w(1, 6, 2, 1));
        exp_m.push_back(w(3, 7, 0, 1));
        exp_r.push_back(1); exp_r.push_back(3);
        wait_drain("multi", 1'b1, 200);
        gap_en = 1'b0;

        // Tag FIFO full: nine packets offered, eight accepted
        r_tready = '0;
        for (int k = 0; k < 9; k++) begin
            src_q[k % N].push_back(w(k % N, 8 + k, 0, 1));
            exp_m.push_back(w(k % N, 8 + k, 0, 1));
            exp_r.push_back(k % N);
        end
        repeat (60) @(posedge aclk);
        #2;
        check("full_inflight", 64'(inflight), 64'd8);
        check("full_m_left", 64'(exp_m.size()), 64'd1);
        check("full_m_tvalid", 64'(m_tvalid), 64'd0);
        check("full_s_tready", 64'(s_tready), 64'd0);
        r_tready = '1;
        @(posedge aclk);
        #2;
        r_tready = '0;
        check("pop_inflight", 64'(inflight), 64'd7);
        @(posedge aclk);
        #2;
        check("regrant_inflight", 64'(inflight), 64'd8);
        r_tready = '1;
        wait_drain("full", 1'b1, 300);
        check("full_drained", 64'(inflight), 64'd0);

        // Grants 2,0,1 and the in-order return path
        do_reset("rst2");
        m_tready = 1'b1;
        r_tready = '0;
        d_en     = 1'b1;
        srcs[0] = 2; srcs[1] = 0; srcs[2] = 1;
        for (int j = 0; j < 3; j++) begin
            src_q[srcs[j]].push_back(w(srcs[j], 20 + j, 0, 1));
            exp_m.push_back(w(srcs[j], 20 + j, 0, 1));
            exp_r.push_back(srcs[j]);
            wait_drain("ord", 1'b0, 100);
        end
        repeat (2) @(posedge aclk);
        #2;
        check("ord_inflight", 64'(inflight), 64'd3);
        r_tready = '1;
        wait_drain("ord_ret", 1'b1, 100);
`ifdef SHA2_SCHED_STATS_EN
        exp_stat = {32'd0, 32'd1, 32'd1, 32'd1};
`else
        exp_stat = '0;
`endif
        for (int i = 0; i < N; i++)
            check($sformatf("stat_pkt%0d", i), 64'(stat_pkt[i*32 +: 32]), 64'(exp_stat[i*32 +: 32]));

        // Reset while a packet is stalled mid-transfer
        m_tready = 1'b0;
        src_q[1].push_back(w(1, 30, 0, 0));
        src_q[1].push_back(w(1, 30, 1, 0));
        src_q[1].push_back(w(1, 30, 2, 1));
        repeat (4) @(posedge aclk);
        #2;
        check("mid_m_tvalid", 64'(m_tvalid), 64'd1);
        check("mid_inflight", 64'(inflight), 64'd1);
        #1;
        do_reset("mid_rst");
        repeat (3) @(posedge aclk);
        #2;
        check("post_inflight", 64'(inflight), 64'd0);
        check("post_m_tvalid", 64'(m_tvalid), 64'd0);
        check("post_err_orphan", 64'(err_orphan), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish (checks=%0d failures=%0d)", n_chk, n_fail);
        $fatal(1);
    end

endmodule
`default_nettype wire
